// File: rtl/video_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen_if
// Description : Pixel-fetch and VGA pin bundle for the raster timing generator.
//               master = timing generator, slave = pixel source / DAC side.
// Revision    : 1.0 - initial release
// ============================================================================
interface video_timing_gen_if #(
    parameter int CNT_W      = 10,
    parameter int COLOR_BITS = 4
);
    logic [CNT_W-1:0]        fetch_x;
    logic [CNT_W-1:0]        fetch_y;
    logic                    fetch_valid;
    logic [3*COLOR_BITS-1:0] pix_rgb;
    logic [COLOR_BITS-1:0]   vga_r;
    logic [COLOR_BITS-1:0]   vga_g;
    logic [COLOR_BITS-1:0]   vga_b;
    logic                    vga_hsync;
    logic                    vga_vsync;

    modport master (
        output fetch_x, fetch_y, fetch_valid,
        output vga_r, vga_g, vga_b, vga_hsync, vga_vsync,
        input  pix_rgb
    );

    modport slave (
        input  fetch_x, fetch_y, fetch_valid,
        input  vga_r, vga_g, vga_b, vga_hsync, vga_vsync,
        output pix_rgb
    );
endinterface
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen
// Description : Parametrised VGA raster timing generator with pixel-fetch
//               interface, latency-matched sync/colour pipeline, line
//               interrupt, vblank/frame pulses and a frame counter.
// Revision    : 1.0 - initial release
// ============================================================================
module video_timing_gen #(
    parameter int H_ACTIVE      = 640,
    parameter int H_FRONT_PORCH = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BACK_PORCH  = 48,
    parameter int V_ACTIVE      = 480,
    parameter int V_FRONT_PORCH = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BACK_PORCH  = 33,
    parameter bit HSYNC_POL     = 1'b0,
    parameter bit VSYNC_POL     = 1'b0,
    parameter int CNT_W         = 10,
    parameter int COLOR_BITS    = 4,
    parameter int PIX_LATENCY   = 2
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    input  wire logic                    en_i,
    input  wire logic [3*COLOR_BITS-1:0] border_rgb_i,
    input  wire logic [CNT_W-1:0]        irq_line_i,
    video_timing_gen_if.master           vga_if,
    output logic                         line_irq_o,
    output logic                         vblank_start_o,
    output logic                         frame_start_o,
    output logic [15:0]                  frame_count_o
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;

    localparam logic [CNT_W-1:0] C_H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] C_V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] C_H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] C_V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] C_HS_BEG = CNT_W'(H_ACTIVE + H_FRONT_PORCH);
    localparam logic [CNT_W-1:0] C_HS_END = CNT_W'(H_ACTIVE + H_FRONT_PORCH + H_SYNC);
    localparam logic [CNT_W-1:0] C_VS_BEG = CNT_W'(V_ACTIVE + V_FRONT_PORCH);
    localparam logic [CNT_W-1:0] C_VS_END = CNT_W'(V_ACTIVE + V_FRONT_PORCH + V_SYNC);

    logic [CNT_W-1:0]        x_q, x_d;
    logic [CNT_W-1:0]        y_q, y_d;
    logic                    line_irq_q, line_irq_d;
    logic                    vblank_q, vblank_d;
    logic                    frame_q, frame_d;
    logic [15:0]             fcnt_q, fcnt_d;
    logic [3*COLOR_BITS-1:0] rgb_q, rgb_d;
    logic                    hs_q, hs_d;
    logic                    vs_q, vs_d;

    logic                    w_active;
    logic                    w_hs;
    logic                    w_vs;
    logic                    w_at_x0;
    logic                    w_h_last;
    logic                    w_v_last;
    logic [2:0]              w_stage_in;   // {active, hsync, vsync}
    logic [2:0]              w_dly_out;

    // Raster decode; everything is gated by en so a held raster looks blank
    always_comb begin
        w_h_last   = (x_q == C_H_LAST);
        w_v_last   = (y_q == C_V_LAST);
        w_active   = en_i && (x_q < C_H_ACT) && (y_q < C_V_ACT);
        w_hs       = en_i && (x_q >= C_HS_BEG) && (x_q < C_HS_END);
        w_vs       = en_i && (y_q >= C_VS_BEG) && (y_q < C_VS_END);
        w_at_x0    = en_i && (x_q == '0);
        w_stage_in = {w_active, w_hs, w_vs};
    end

    // Next-state for counters, pulses and the frame counter
    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        fcnt_d     = fcnt_q;
        line_irq_d = w_at_x0 && (y_q == irq_line_i);
        vblank_d   = w_at_x0 && (y_q == C_V_ACT);
        frame_d    = w_at_x0 && (y_q == '0);
        if (!en_i) begin
            x_d = '0;
            y_d = '0;
        end else if (w_h_last) begin
            x_d = '0;
            if (w_v_last) begin
                y_d    = '0;
                fcnt_d = fcnt_q + 16'd1;
            end else begin
                y_d = y_q + 1'b1;
            end
        end else begin
            x_d = x_q + 1'b1;
        end
    end

    // Delay line matching active/sync to the pixel-fetch return latency
    generate
        if (PIX_LATENCY == 0) begin : g_no_dly
            assign w_dly_out = w_stage_in;
        end else begin : g_dly
            logic [2:0] dly_q [PIX_LATENCY];

            // Shift register; en low naturally shifts in inactive entries
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < PIX_LATENCY; i++) begin
                        dly_q[i] <= 3'b000;
                    end
                end else begin
                    dly_q[0] <= w_stage_in;
                    for (int i = 1; i < PIX_LATENCY; i++) begin
                        dly_q[i] <= dly_q[i-1];
                    end
                end
            end

            assign w_dly_out = dly_q[PIX_LATENCY-1];
        end
    endgenerate

    // Pin-side colour and sync selection ahead of the output register
    always_comb begin
        rgb_d = w_dly_out[2] ? vga_if.pix_rgb : border_rgb_i;
        hs_d  = w_dly_out[1] ? HSYNC_POL : ~HSYNC_POL;
        vs_d  = w_dly_out[0] ? VSYNC_POL : ~VSYNC_POL;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q        <= '0;
            y_q        <= '0;
            line_irq_q <= 1'b0;
            vblank_q   <= 1'b0;
            frame_q    <= 1'b0;
            fcnt_q     <= 16'd0;
            rgb_q      <= '0;
            hs_q       <= ~HSYNC_POL;
            vs_q       <= ~VSYNC_POL;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            line_irq_q <= line_irq_d;
            vblank_q   <= vblank_d;
            frame_q    <= frame_d;
            fcnt_q     <= fcnt_d;
            rgb_q      <= rgb_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
        end
    end

    assign vga_if.fetch_x     = x_q;
    assign vga_if.fetch_y     = y_q;
    assign vga_if.fetch_valid = w_active;
    assign vga_if.vga_r       = rgb_q[3*COLOR_BITS-1:2*COLOR_BITS];
    assign vga_if.vga_g       = rgb_q[2*COLOR_BITS-1:COLOR_BITS];
    assign vga_if.vga_b       = rgb_q[COLOR_BITS-1:0];
    assign vga_if.vga_hsync   = hs_q;
    assign vga_if.vga_vsync   = vs_q;
    assign line_irq_o         = line_irq_q;
    assign vblank_start_o     = vblank_q;
    assign frame_start_o      = frame_q;
    assign frame_count_o      = fcnt_q;
endmodule
`default_nettype wire

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised VGA raster timing generator: the next generation of the fixed 640x480 timing block. It drives the same VGA pin interface, with configurable timing and colour depth, selectable sync polarity, and a pixel-fetch interface with configurable return latency. It also provides a programmable line interrupt, vblank/frame pulses and a frame counter, and sits between the composer/pixel source and the VGA DAC pins.

## Interface
- H_ACTIVE, 640; H_FRONT_PORCH, 16; H_SYNC, 96; H_BACK_PORCH, 48: horizontal timing in pixel clocks.
- V_ACTIVE, 480; V_FRONT_PORCH, 10; V_SYNC, 2; V_BACK_PORCH, 33: vertical timing in lines.
- HSYNC_POL, 0; VSYNC_POL, 0: asserted sync level (0 = active-low).
- CNT_W, 10: x/y counter width; must satisfy 2^CNT_W >= H_TOTAL and 2^CNT_W >= V_TOTAL.
- COLOR_BITS, 4: bits per colour channel.
- PIX_LATENCY, 2: cycles from fetch request to pix_rgb valid; range 0..7.
- clk  in  1  pixel clock.
- rst_n  in  1  **asynchronous, active-low reset**.
- en  in  1  timing enable; low holds raster at origin and blanks.
- border_rgb  in  3*COLOR_BITS  colour driven outside the active area ({r,g,b}).
- irq_line  in  CNT_W  line number for line_irq.
- fetch_x, fetch_y  out  CNT_W each  current raster position (combinational from counters).
- fetch_valid  out  1  position is in the active area.
- pix_rgb  in  3*COLOR_BITS  pixel data for the fetch issued PIX_LATENCY cycles earlier.
- vga_r, vga_g, vga_b  out  COLOR_BITS each  registered colour.
- vga_hsync, vga_vsync  out  1  registered sync, polarity per parameter.
- line_irq  out  1  one-cycle pulse.
- vblank_start  out  1  one-cycle pulse.
- frame_start  out  1  one-cycle pulse.
- frame_count  out  16  frames completed, wraps.

## Operation
- Totals: H_TOTAL = sum of the H parameters; V_TOTAL = sum of the V parameters.
- x counts 0..H_TOTAL-1. At x==H_TOTAL-1, y advances; it wraps from V_TOTAL-1 to 0.
- active = (x < H_ACTIVE) && (y < V_ACTIVE).
- hsync asserted for H_ACTIVE+H_FRONT_PORCH <= x < H_ACTIVE+H_FRONT_PORCH+H_SYNC.
- vsync asserted for V_ACTIVE+V_FRONT_PORCH <= y < V_ACTIVE+V_FRONT_PORCH+V_SYNC.
- fetch_x=x, fetch_y=y, fetch_valid=active; these are combinational, in the same cycle as the counters.
- active, hsync and vsync pass through a PIX_LATENCY-stage shift register, then the output register:
  - colour = delayed_active ? pix_rgb : border_rgb;
  - sync pin = delayed_sync ? POL : ~POL.
- line_irq is registered high for one cycle when x==0 and y==irq_line. irq_line >= V_TOTAL never fires.
- vblank_start is registered high when x==0 and y==V_ACTIVE.
- frame_start is registered high when x==0 and y==0.
- frame_count increments on the x==H_TOTAL-1, y==V_TOTAL-1 wrap, modulo 2^16.
- en low (synchronous):
  - x and y are forced to 0;
  - fetch_valid=0;
  - delay-line entries are loaded inactive;
  - pulses are suppressed;
  - frame_count holds.
- When en rises, x=0, y=0 is the first counted cycle. frame_start fires for it, with no increment of frame_count.

## Timing
- Reset (rst_n low, asynchronous):
  - x=y=0; delay line inactive; vga_r/g/b=0;
  - vga_hsync=~HSYNC_POL, vga_vsync=~VSYNC_POL;
  - line_irq=vblank_start=frame_start=0; frame_count=0.
- Reset asserted mid-frame returns all state immediately. The first counted position after release is (0,0).
- Latency, counter position to VGA pins: PIX_LATENCY+1 clocks for colour and sync alike, so they stay aligned. PIX_LATENCY=0 gives one-clock latency.
- Pulse outputs have 1-clock latency from the qualifying counter position and are not delayed by PIX_LATENCY.
- line_irq equal to 0 coincides with frame_start; both fire.
- irq_line changes take effect at the next x==0 comparison.

## Test plan
Bench parameters: H=8/2/3/3 (H_TOTAL=16), V=4/1/2/1 (V_TOTAL=8), POL=0, COLOR_BITS=4, PIX_LATENCY=2.
- Reset then release, pix_rgb=12'hABC, border_rgb=12'h123:
  - during reset, outputs are 0 and both syncs are 1;
  - cycles 3..10 after release give RGB=A,B,C;
  - cycles 11..18 give 1,2,3.
- Sync check: vga_hsync low exactly for released cycles 13..15 of each line. vga_vsync low for lines 5..6 (cycles 83..114 after release).
- Pulse check with irq_line=3:
  - line_irq pulses one clock after x=0,y=3 (released cycle 49);
  - vblank_start pulses at cycle 65;
  - frame_start pulses at cycles 1 and 129;
  - frame_count=1 after cycle 128.
- irq_line=9 (>= V_TOTAL) over 3 frames: line_irq stays 0.
- en drop mid-line at y=2,x=5:
  - next cycle fetch_valid=0 and x=y=0;
  - after the 2-stage flush, RGB=border and syncs are inactive;
  - en high again: frame_start pulses, frame_count unchanged.
- rst_n pulse at y=5 with vsync asserted: vga_vsync goes 1 and all counters go 0 without waiting for a clock. The frame restarts at (0,0) after release.
